result_bcd_fmt: RTL and testbench

Formats a signed fixed-point value (scaled ×10000, two's complement) into eight display digits with decimal point, sign and overflow flags. It sits downstream of the calculator logic's `operand1`/`operand2`/`result` outputs and feeds the 8-digit 7-segment scanner. Conversion is iterative: 64-step double-dabble, then trailing-digit alignment and zero trimming. A start/busy/done handshake frames each conversion.

---
 rtl/result_bcd_fmt.sv | 150 +++++++++++++++
 tb/tb_result_bcd_fmt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_fmt.sv
// Signed fixed-point (x10000) to 8-digit BCD display formatter.
// Iterative double-dabble, then digit alignment / trailing-zero trim.
module result_bcd_fmt (
  input  logic        clk_db,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] value,
  output logic        busy,
  output logic        done,
  output logic [31:0] digits,
  output logic [2:0]  dp_pos,
  output logic        is_negative,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_FMT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [63:0] mag;
  logic [79:0] bcd;
  logic [79:0] bcd_adj;
  logic [5:0]  cnt;
  logic        neg;
  logic        ovf;
  logic [3:0]  n_r;
  logic [2:0]  keep;
  logic [2:0]  drop;
  logic [4:0]  hi;
  logic [4:0]  n_calc;
  logic [2:0]  keep_calc;
  logic [31:0] digits_fmt;
  logic        shift_now;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 20; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Integer width n = highest nonzero integer digit index - 3, at least 1.
  always_comb begin
    hi = '0;
    for (int unsigned i = 4; i < 20; i++) begin
      if (bcd[4*i +: 4] != 4'd0) hi = 5'(i);
    end
    n_calc    = (hi > 5'd4) ? (hi - 5'd3) : 5'd1;
    keep_calc = (n_calc <= 5'd4) ? 3'd4 : 3'(5'd8 - n_calc);
  end

  always_comb begin
    digits_fmt = '1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(n_r) + 32'(keep)) digits_fmt[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  assign shift_now = (drop != 3'd0) || ((keep != 3'd0) && (bcd[3:0] == 4'd0));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CONV;
      S_CONV:  if (cnt == 6'd63) state_next = S_FMT;
      S_FMT:   state_next = (n_calc > 5'd8) ? S_DONE : S_SHIFT;
      S_SHIFT: if (!shift_now) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_db) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk_db) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      digits      <= '1;
      dp_pos      <= '0;
      is_negative <= 1'b0;
      overflow    <= 1'b0;
      mag         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      ovf         <= 1'b0;
      n_r         <= '0;
      keep        <= '0;
      drop        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mag  <= value[63] ? (~value + 64'd1) : value;
            neg  <= value[63];
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        S_CONV: begin
          bcd <= {bcd_adj[78:0], mag[63]};
          mag <= {mag[62:0], 1'b0};
          cnt <= cnt + 6'd1;
        end
        S_FMT: begin
          ovf  <= (n_calc > 5'd8);
          n_r  <= n_calc[3:0];
          keep <= keep_calc;
          drop <= 3'd4 - keep_calc;
        end
        S_SHIFT: begin
          // Dropped digits are truncated first, then trailing zeros trimmed.
          if (drop != 3'd0) begin
            bcd  <= {4'h0, bcd[79:4]};
            drop <= drop - 3'd1;
          end else if ((keep != 3'd0) && (bcd[3:0] == 4'd0)) begin
            bcd  <= {4'h0, bcd[79:4]};
            keep <= keep - 3'd1;
          end
        end
        S_DONE: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          is_negative <= neg;
          overflow    <= ovf;
          if (ovf) begin
            digits <= '1;
            dp_pos <= '0;
          end else begin
            digits <= digits_fmt;
            dp_pos <= keep;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_fmt.sv
// Directed self-checking bench for result_bcd_fmt.
module tb_result_bcd_fmt;

  logic        clk_db = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] value;
  logic        busy;
  logic        done;
  logic [31:0] digits;
  logic [2:0]  dp_pos;
  logic        is_negative;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk_db = ~clk_db;

  result_bcd_fmt dut (
    .clk_db      (clk_db),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .digits      (digits),
    .dp_pos      (dp_pos),
    .is_negative (is_negative),
    .overflow    (overflow)
  );

  // Stimulus only: start one conversion, report edges from t0 to done (-1 on timeout).
  task automatic run_conv(input logic [63:0] v, output int lat, output bit busy_ok);
    @(negedge clk_db);
    value = v;
    start = 1'b1;
    @(posedge clk_db); #1;
    start   = 1'b0;
    busy_ok = busy;
    lat     = -1;
    for (int e = 1; e < 200; e++) begin
      @(posedge clk_db); #1;
      if (done) begin lat = e; break; end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; value = '0;
    repeat (2) @(posedge clk_db);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (digits !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_digits got=%h exp=ffffffff", digits); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL reset_dp got=%0d exp=0", dp_pos); end
    checks++; if (is_negative !== 1'b0) begin failures++; $display("FAIL reset_neg got=%b exp=0", is_negative); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk_db);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit bok;
    run_conv(64'd1234500, lat, bok);
    checks++; if (lat !== 69) begin failures++; $display("FAIL basic_latency got=%0d exp=69", lat); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bok); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    checks++; if (digits !== 32'hFFF12345) begin failures++; $display("FAIL basic_digits got=%h exp=fff12345", digits); end
    checks++; if (dp_pos !== 3'd2) begin failures++; $display("FAIL basic_dp got=%0d exp=2", dp_pos); end
    checks++; if (is_negative !== 1'b0) begin failures++; $display("FAIL basic_neg got=%b exp=0", is_negative); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    @(posedge clk_db); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (digits !== 32'hFFF12345) begin failures++; $display("FAIL basic_hold got=%h exp=fff12345", digits); end
  endtask

  task automatic test_zero();
    int lat; bit bok;
    run_conv(64'd0, lat, bok);
    checks++; if (lat !== 71) begin failures++; $display("FAIL zero_latency got=%0d exp=71", lat); end
    checks++; if (digits !== 32'hFFFFFFF0) begin failures++; $display("FAIL zero_digits got=%h exp=fffffff0", digits); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL zero_dp got=%0d exp=0", dp_pos); end
    checks++; if (is_negative !== 1'b0) begin failures++; $display("FAIL zero_neg got=%b exp=0", is_negative); end
  endtask

  task automatic test_negative();
    int lat; bit bok;
    run_conv(-64'sd25000, lat, bok);
    checks++; if (lat !== 70) begin failures++; $display("FAIL neg_latency got=%0d exp=70", lat); end
    checks++; if (digits !== 32'hFFFFFF25) begin failures++; $display("FAIL neg_digits got=%h exp=ffffff25", digits); end
    checks++; if (dp_pos !== 3'd1) begin failures++; $display("FAIL neg_dp got=%0d exp=1", dp_pos); end
    checks++; if (is_negative !== 1'b1) begin failures++; $display("FAIL neg_neg got=%b exp=1", is_negative); end
  endtask

  task automatic test_full_width();
    int lat; bit bok;
    run_conv(64'd123456789012, lat, bok);
    checks++; if (lat !== 71) begin failures++; $display("FAIL full_latency got=%0d exp=71", lat); end
    checks++; if (digits !== 32'h12345678) begin failures++; $display("FAIL full_digits got=%h exp=12345678", digits); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL full_dp got=%0d exp=0", dp_pos); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    int lat; bit bok;
    run_conv(64'd1000000000000, lat, bok);
    checks++; if (lat !== 66) begin failures++; $display("FAIL ovf_pos_latency got=%0d exp=66", lat); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pos_flag got=%b exp=1", overflow); end
    checks++; if (digits !== 32'hFFFFFFFF) begin failures++; $display("FAIL ovf_pos_digits got=%h exp=ffffffff", digits); end
    checks++; if (is_negative !== 1'b0) begin failures++; $display("FAIL ovf_pos_neg got=%b exp=0", is_negative); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL ovf_pos_dp got=%0d exp=0", dp_pos); end
    run_conv(64'h8000000000000000, lat, bok);
    checks++; if (lat !== 66) begin failures++; $display("FAIL ovf_min_latency got=%0d exp=66", lat); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_min_flag got=%b exp=1", overflow); end
    checks++; if (digits !== 32'hFFFFFFFF) begin failures++; $display("FAIL ovf_min_digits got=%h exp=ffffffff", digits); end
    checks++; if (is_negative !== 1'b1) begin failures++; $display("FAIL ovf_min_neg got=%b exp=1", is_negative); end
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    bit extra_done = 1'b0;
    @(negedge clk_db);
    value = 64'd1234500; start = 1'b1;
    @(posedge clk_db); #1;
    start = 1'b0;
    for (int e = 1; e < 200; e++) begin
      if (e == 10) begin
        @(negedge clk_db);
        value = 64'd99990000; start = 1'b1;
      end
      @(posedge clk_db); #1;
      start = 1'b0;
      value = 64'd77770000;
      if (done) begin lat = e; break; end
    end
    checks++; if (lat !== 69) begin failures++; $display("FAIL ignore_latency got=%0d exp=69", lat); end
    checks++; if (digits !== 32'hFFF12345) begin failures++; $display("FAIL ignore_digits got=%h exp=fff12345", digits); end
    for (int e = 0; e < 80; e++) begin
      @(posedge clk_db); #1;
      if (done || busy) extra_done = 1'b1;
    end
    checks++; if (extra_done !== 1'b0) begin failures++; $display("FAIL ignore_not_queued got=%b exp=0", extra_done); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk_db);
    value = 64'd1234500; start = 1'b1;
    @(posedge clk_db); #1;
    start = 1'b0;
    repeat (28) @(posedge clk_db);
    @(negedge clk_db);
    rst = 1'b1; start = 1'b1; value = 64'd10000;
    @(posedge clk_db); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (digits !== 32'hFFFFFFFF) begin failures++; $display("FAIL midrst_digits got=%h exp=ffffffff", digits); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL midrst_dp got=%0d exp=0", dp_pos); end
    @(negedge clk_db);
    rst = 1'b0; start = 1'b0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk_db); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok;
    int lat2 = -1;
    run_conv(64'd10000, lat, bok);
    checks++; if (lat !== 71) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=71", lat); end
    checks++; if (digits !== 32'hFFFFFFF1) begin failures++; $display("FAIL b2b_first_digits got=%h exp=fffffff1", digits); end
    checks++; if (dp_pos !== 3'd0) begin failures++; $display("FAIL b2b_first_dp got=%0d exp=0", dp_pos); end
    // Still in the done cycle: a start here must be accepted on the next edge.
    value = -64'sd25000; start = 1'b1;
    @(posedge clk_db); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_low got=%b exp=0", done); end
    for (int e = 1; e < 200; e++) begin
      @(posedge clk_db); #1;
      if (done) begin lat2 = e; break; end
    end
    checks++; if (lat2 !== 70) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=70", lat2); end
    checks++; if (digits !== 32'hFFFFFF25) begin failures++; $display("FAIL b2b_second_digits got=%h exp=ffffff25", digits); end
    checks++; if (is_negative !== 1'b1) begin failures++; $display("FAIL b2b_second_neg got=%b exp=1", is_negative); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_negative();
    test_full_width();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
